// File: rtl/ram_rr_arbiter_if.sv
// ram_rr_arbiter_if: bundle between the requesting cores, the shared RAM and
// the round-robin arbiter.
//   Core side : req/rw/lock/addr/wdata in, ack/rdata/grant_id/busy out.
//   RAM side  : ram_addr/ram_wdata/ram_we out, ram_rdata in.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever drives the cores and hosts the RAM.
interface ram_rr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int AW    = 9,
  parameter int DW    = 8
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    rw;
  logic [N_REQ-1:0]    lock;
  logic [N_REQ*AW-1:0] addr;
  logic [N_REQ*DW-1:0] wdata;
  logic [N_REQ-1:0]    ack;
  logic [DW-1:0]       rdata;
  logic [IW-1:0]       grant_id;
  logic                busy;
  logic [AW-1:0]       ram_addr;
  logic [DW-1:0]       ram_wdata;
  logic                ram_we;
  logic [DW-1:0]       ram_rdata;

  modport slave (
    input  req, rw, lock, addr, wdata, ram_rdata,
    output ack, rdata, grant_id, busy, ram_addr, ram_wdata, ram_we
  );

  modport master (
    output req, rw, lock, addr, wdata, ram_rdata,
    input  ack, rdata, grant_id, busy, ram_addr, ram_wdata, ram_we
  );
endinterface

// File: rtl/ram_rr_arbiter.sv
// ram_rr_arbiter: shares one single-port synchronous RAM between N_REQ cores.
// Transactions are serialised round-robin; a requester may keep ownership for
// up to MAX_LOCK consecutive transactions through its lock bit.
//   clk   : clock, all logic on posedge
//   reset : synchronous, active-high
//   bus   : core handshake (req/rw/lock/addr/wdata -> ack/rdata/grant_id/busy)
//           and RAM port (ram_addr/ram_wdata/ram_we -> ram_rdata)
// Writes take 2 cycles (grant, ack); reads take 3 (grant, RAM access, ack).
module ram_rr_arbiter #(
  parameter int N_REQ    = 4,
  parameter int AW       = 9,
  parameter int DW       = 8,
  parameter int MAX_LOCK = 8
) (
  input  logic            clk,
  input  logic            reset,
  ram_rr_arbiter_if.slave bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_ADDR = 2'd2,
    RD_DATA = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    gid_q, gid_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic             owner_valid_q, owner_valid_d;
  logic [CW-1:0]    lock_cnt_q, lock_cnt_d;
  logic             lock_q, lock_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [AW-1:0]    ram_addr_q, ram_addr_d;
  logic [DW-1:0]    ram_wdata_q, ram_wdata_d;
  logic             ram_we_q, ram_we_d;

  logic [N_REQ-1:0] elig_s;
  logic             win_found_s;
  logic [IW-1:0]    win_idx_s;
  logic             done_s;

  // Eligible requesters: ack mask stops a still-high req being re-granted in
  // its own ack cycle; a valid owner shuts everyone else out.
  always_comb begin
    elig_s = bus.req & ~ack_q &
             (owner_valid_q ? (ONE_HOT0 << owner_q) : {N_REQ{1'b1}});
  end

  // Round-robin search starting one past the last winner.
  always_comb begin
    logic [IW-1:0] cand;
    cand        = '0;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand        = IW'((32'(ptr_q) + 32'(i)) % 32'(N_REQ));
      win_idx_s   = (!win_found_s && elig_s[cand]) ? cand : win_idx_s;
      win_found_s = win_found_s | elig_s[cand];
    end
  end

  // Transaction sequencing: next state, RAM port and core-side outputs.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gid_d       = gid_q;
    lock_d      = lock_q;
    ack_d       = {N_REQ{1'b0}};
    rdata_d     = rdata_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = ram_we_q;
    done_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found_s) begin
          ram_addr_d  = bus.addr[32'(win_idx_s)*AW +: AW];
          ram_we_d    = bus.rw[win_idx_s];
          // ram_wdata only moves for writes so it holds across reads
          ram_wdata_d = bus.rw[win_idx_s] ? bus.wdata[32'(win_idx_s)*DW +: DW]
                                          : ram_wdata_q;
          lock_d      = bus.lock[win_idx_s];
          gid_d       = win_idx_s;
          ptr_d       = win_idx_s;
          state_d     = bus.rw[win_idx_s] ? WR : RD_ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      WR: begin
        ram_we_d = 1'b0;
        ack_d    = ONE_HOT0 << gid_q;
        done_s   = 1'b1;
        state_d  = IDLE;
      end
      RD_ADDR: begin
        // RAM captures ram_addr at the end of this cycle
        state_d = RD_DATA;
      end
      RD_DATA: begin
        rdata_d = bus.ram_rdata;
        ack_d   = ONE_HOT0 << gid_q;
        done_s  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Ownership bookkeeping on transaction completion; the release happens on
  // the MAX_LOCK-th consecutive locked transaction even if lock stays high.
  always_comb begin
    owner_d       = owner_q;
    owner_valid_d = owner_valid_q;
    lock_cnt_d    = lock_cnt_q;
    if (done_s) begin
      if (lock_q && ((32'(lock_cnt_q) + 32'd1) < 32'(MAX_LOCK))) begin
        owner_d       = gid_q;
        owner_valid_d = 1'b1;
        lock_cnt_d    = lock_cnt_q + CW'(1);
      end else begin
        owner_valid_d = 1'b0;
        lock_cnt_d    = '0;
      end
    end else begin
      owner_valid_d = owner_valid_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      ptr_q         <= IW'(N_REQ - 1);
      gid_q         <= '0;
      owner_q       <= '0;
      owner_valid_q <= 1'b0;
      lock_cnt_q    <= '0;
      lock_q        <= 1'b0;
      ack_q         <= '0;
      rdata_q       <= '0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      ram_we_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      gid_q         <= gid_d;
      owner_q       <= owner_d;
      owner_valid_q <= owner_valid_d;
      lock_cnt_q    <= lock_cnt_d;
      lock_q        <= lock_d;
      ack_q         <= ack_d;
      rdata_q       <= rdata_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      ram_we_q      <= ram_we_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.rdata     = rdata_q;
  assign bus.grant_id  = gid_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.ram_we    = ram_we_q;
endmodule
